// File: rtl/quick_cpu_imem_if.sv
// Load and fetch bundle between host/CPU (master) and the instruction memory (slave).
// QUICK_CPU_IMEM_CHECKSUM_EN adds the ld_sum return signal.
interface quick_cpu_imem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_last;
    logic              ld_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_oob;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] ld_sum;
`endif

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        input  ld_ready, ld_done, fetch_valid, fetch_data, fetch_oob
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
        , input ld_sum
`endif
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        output ld_ready, ld_done, fetch_valid, fetch_data, fetch_oob
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
        , output ld_sum
`endif
    );
endinterface

// File: rtl/quick_cpu_imem.sv
// Quick CPU program memory: byte-serial program load, then 1-cycle-latency fetch.
// Optional QUICK_CPU_IMEM_CHECKSUM_EN exposes a running byte sum of the loaded program.
module quick_cpu_imem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic               clk,
    input logic               rst,
    quick_cpu_imem_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  prog_len_q, prog_len_d;
    logic [DEPTH-1:0]  wr_q, wr_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_oob_q, fetch_oob_d;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic              xfer;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  fidx;
    logic              f_oob;
    logic              f_hit;

    // A restart pulse owns the cycle: the host sees ld_ready low so the byte is not lost silently.
    assign bus.ld_ready = (state_q == LOAD) && (wptr_q < PTR_W'(DEPTH)) && !bus.ld_start;
    assign xfer         = bus.ld_valid && bus.ld_ready;
    assign widx         = wptr_q[IDX_W-1:0];

    assign fidx  = bus.fetch_addr[IDX_W-1:0];
    assign f_oob = ({1'b0, bus.fetch_addr} >= (ADDR_W+1)'(DEPTH));
    assign f_hit = !f_oob && ({1'b0, fidx} < prog_len_q) && wr_q[fidx];

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        wptr_d        = wptr_q;
        prog_len_d    = prog_len_q;
        wr_d          = wr_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        fetch_oob_d   = fetch_oob_q;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
        sum_d         = sum_q;
`endif

        if ((state_q == RUN) && bus.fetch_req) begin
            fetch_valid_d = 1'b1;
            fetch_oob_d   = f_oob;
            fetch_data_d  = f_hit ? mem[fidx] : '0;
        end

        if (bus.ld_start) begin
            state_d = LOAD;
            wptr_d  = '0;
            wr_d    = '0;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else if (xfer) begin
            wr_d[widx] = 1'b1;
            wptr_d     = wptr_q + 1'b1;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
            sum_d      = sum_q + bus.ld_data;
`endif
            if (bus.ld_last || (wptr_q == PTR_W'(DEPTH - 1))) begin
                state_d    = RUN;
                prog_len_d = wptr_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            wr_q          <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_oob_q   <= 1'b0;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            prog_len_q    <= prog_len_d;
            wr_q          <= wr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_oob_q   <= fetch_oob_d;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    // NOTE: the array has no reset; the per-entry written bits make stale contents read as zero.
    always_ff @(posedge clk) begin
        if (xfer) mem[widx] <= bus.ld_data;
    end

    assign bus.ld_done     = (state_q == RUN);
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_oob   = fetch_oob_q;
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
    assign bus.ld_sum      = sum_q;
`endif
endmodule

// File: tb/tb_quick_cpu_imem.sv
// Directed self-checking bench for quick_cpu_imem (DEPTH=16, 8-bit address and data).
// Checksum expectations are compiled in when QUICK_CPU_IMEM_CHECKSUM_EN is defined.
module tb_quick_cpu_imem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    quick_cpu_imem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    quick_cpu_imem #(.DEPTH(16), .ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and registered outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ld_start   = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = 8'h00;
        bus.ld_last    = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 8'h00;
    endtask

    task automatic start_load(input string tag);
        bus.ld_start = 1'b1;
        #1 check({tag, "_ready_on_start"}, 32'(bus.ld_ready), 32'd0);
        cyc();
        bus.ld_start = 1'b0;
        #1 check({tag, "_done_low_in_load"}, 32'(bus.ld_done), 32'd0);
    endtask

    task automatic put_byte(input string tag, input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        #1 check({tag, "_ready"}, 32'(bus.ld_ready), 32'd1);
        cyc();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] addr,
                         input logic [7:0] exp_data, input logic exp_oob);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        cyc();
        check({tag, "_valid"}, 32'(bus.fetch_valid), 32'd1);
        check({tag, "_data"},  32'(bus.fetch_data),  32'(exp_data));
        check({tag, "_oob"},   32'(bus.fetch_oob),   32'(exp_oob));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        check("rst_ld_ready",    32'(bus.ld_ready),    32'd0);
        check("rst_ld_done",     32'(bus.ld_done),     32'd0);
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_fetch_data",  32'(bus.fetch_data),  32'd0);
        check("rst_fetch_oob",   32'(bus.fetch_oob),   32'd0);
        rst = 1'b0;

        // IDLE ignores fetches and stray load bytes
        bus.fetch_req = 1'b1;
        bus.ld_valid  = 1'b1;
        #1 check("idle_ld_ready", 32'(bus.ld_ready), 32'd0);
        cyc();
        check("idle_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("idle_ld_done",     32'(bus.ld_done),     32'd0);
        clear_inputs();

        // Test 1: three bytes, ld_last on the third, then back-to-back fetches
        start_load("t1");
        put_byte("t1_b0", 8'h11, 1'b0);
        check("t1_done_after_b0", 32'(bus.ld_done), 32'd0);
        put_byte("t1_b1", 8'h22, 1'b0);
        put_byte("t1_b2", 8'h33, 1'b1);
        check("t1_ld_done",  32'(bus.ld_done),  32'd1);
        check("t1_ld_ready", 32'(bus.ld_ready), 32'd0);
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
        check("t1_ld_sum", 32'(bus.ld_sum), 32'h66);
`endif
        fetch("t1_f0", 8'd0, 8'h11, 1'b0);
        fetch("t1_f1", 8'd1, 8'h22, 1'b0);
        fetch("t1_f2", 8'd2, 8'h33, 1'b0);
        bus.fetch_req = 1'b0;
        cyc();
        check("t1_idle_valid", 32'(bus.fetch_valid), 32'd0);
        check("t1_hold_data",  32'(bus.fetch_data),  32'h33);

        // Test 2: full 16-byte load without ld_last
        start_load("t2");
        for (int i = 0; i < 16; i++) put_byte("t2_b", 8'(i), 1'b0);
        check("t2_ready_full", 32'(bus.ld_ready), 32'd0);
        check("t2_ld_done",    32'(bus.ld_done),  32'd1);
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
        check("t2_ld_sum", 32'(bus.ld_sum), 32'h78);
`endif
        fetch("t2_f15", 8'd15, 8'h0F, 1'b0);
        fetch("t2_f16", 8'd16, 8'h00, 1'b1);
        fetch("t2_f255", 8'd255, 8'h00, 1'b1);
        fetch("t2_f7", 8'd7, 8'h07, 1'b0);
        clear_inputs();

        // Test 3: two bytes; an unwritten in-range address reads zero
        start_load("t3");
        put_byte("t3_b0", 8'hAA, 1'b0);
        put_byte("t3_b1", 8'hBB, 1'b1);
        check("t3_ld_done", 32'(bus.ld_done), 32'd1);
        fetch("t3_f5", 8'd5, 8'h00, 1'b0);
        fetch("t3_f1", 8'd1, 8'hBB, 1'b0);
        clear_inputs();

        // Test 4: fetch_req held during LOAD, gap in ld_valid inserts nothing
        start_load("t4");
        bus.fetch_req = 1'b1;
        put_byte("t4_b0", 8'h01, 1'b0);
        check("t4_fv_0", 32'(bus.fetch_valid), 32'd0);
        bus.ld_data = 8'hEE;
        cyc();
        check("t4_fv_gap", 32'(bus.fetch_valid), 32'd0);
        bus.fetch_req = 1'b0;
        put_byte("t4_b1", 8'h02, 1'b1);
        check("t4_fv_1",   32'(bus.fetch_valid), 32'd0);
        check("t4_ld_done", 32'(bus.ld_done),    32'd1);
        fetch("t4_f0", 8'd0, 8'h01, 1'b0);
        fetch("t4_f1", 8'd1, 8'h02, 1'b0);
        fetch("t4_f2", 8'd2, 8'h00, 1'b0);
        clear_inputs();

        // Test 5: ld_start with ld_valid in RUN drops the byte
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h77;
        #1 check("t5_ready_on_start", 32'(bus.ld_ready), 32'd0);
        cyc();
        clear_inputs();
        check("t5_ld_done", 32'(bus.ld_done), 32'd0);
        put_byte("t5_b0", 8'h5A, 1'b1);
        check("t5_ld_done_reload", 32'(bus.ld_done), 32'd1);
`ifdef QUICK_CPU_IMEM_CHECKSUM_EN
        check("t5_ld_sum", 32'(bus.ld_sum), 32'h5A);
`endif
        fetch("t5_f0", 8'd0, 8'h5A, 1'b0);
        fetch("t5_f1", 8'd1, 8'h00, 1'b0);

        // Test 6: reset in the cycle after a fetch request drops the result
        fetch("t6_pre", 8'd0, 8'h5A, 1'b0);
        rst = 1'b1;
        cyc();
        check("t6_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("t6_fetch_data",  32'(bus.fetch_data),  32'd0);
        check("t6_ld_done",     32'(bus.ld_done),     32'd0);
        rst = 1'b0;
        bus.fetch_addr = 8'd0;
        cyc();
        check("t6_fetch_ignored", 32'(bus.fetch_valid), 32'd0);
        clear_inputs();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
